// File: rtl/acc_reg_bank.sv
// Accumulator-centric register bank with two operand read ports.
// Reg 0 is the accumulator; the other registers are general purpose.
// A clear sequencer sweeps every register to zero, from the top index
// down to 0, and reports busy/done. Ops that arrive mid-sweep are dropped
// and flagged on wr_drop.
module acc_reg_bank #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          LUTSet,
    input  logic          regWrite,
    input  logic          regGet,
    input  logic          regSet,
    input  logic          clr_req,
    input  logic [DW-1:0] writeData,
    input  logic [DW-1:0] LUTaddr,
    input  logic [PW-1:0] opRegAddr,
    input  logic [PW-1:0] opRegAddrB,
    output logic [DW-1:0] accData,
    output logic [DW-1:0] opRegData,
    output logic [DW-1:0] opRegDataB,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_drop
);

    localparam int DEPTH = 1 << PW;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] idx;
    logic [DW-1:0] regs [DEPTH];

    logic          any_op;
    logic          ops_open;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [DW-1:0] wr_val;

    assign any_op = LUTSet | regWrite | regGet | regSet;

    // State register and sweep index; idx stops at 0 because the FSM leaves CLEAR there
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && clr_req) begin
                idx <= '1;
            end else if (state == CLEAR && idx != '0) begin
                idx <= idx - 1'b1;
            end
        end
    end

    // Next-state: clr_req only starts a sweep from IDLE; DONE always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = CLEAR;
            CLEAR:   if (idx == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and the single storage write port: sweep clear, or one prioritised op
    always_comb begin
        busy     = (state == CLEAR);
        clr_done = (state == DONE);
        ops_open = (state == DONE) || (state == IDLE && !clr_req);
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_val   = '0;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = idx;
        end else if (ops_open) begin
            if (LUTSet) begin
                wr_en  = 1'b1;
                wr_val = LUTaddr;
            end else if (regWrite) begin
                wr_en  = 1'b1;
                wr_val = writeData;
            end else if (regGet) begin
                // GET from addr 0 rewrites acc with itself, i.e. leaves it unchanged
                wr_en  = 1'b1;
                wr_val = regs[opRegAddr];
            end else if (regSet) begin
                // SET to addr 0 would copy acc onto itself, so it is simply suppressed
                wr_en   = (opRegAddr != '0);
                wr_addr = opRegAddr;
                wr_val  = regs[0];
            end
        end
    end

    // Registered drop flag: pulses the cycle after an op is refused during a sweep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= (state == CLEAR) && any_op;
        end
    end

    // Register storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_val;
        end
    end

    assign accData    = regs[0];
    assign opRegData  = regs[opRegAddr];
    assign opRegDataB = regs[opRegAddrB];

endmodule

// File: tb/tb_acc_reg_bank.sv
// Directed testbench for acc_reg_bank: ops, priority, clear sweep, drops, reset mid-sweep.
module tb_acc_reg_bank;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       LUTSet, regWrite, regGet, regSet, clr_req;
    logic [7:0] writeData, LUTaddr;
    logic [3:0] opRegAddr, opRegAddrB;
    logic [7:0] accData, opRegData, opRegDataB;
    logic       busy, clr_done, wr_drop;

    int checks = 0;
    int errors = 0;

    acc_reg_bank #(.DW(8), .PW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .LUTSet     (LUTSet),
        .regWrite   (regWrite),
        .regGet     (regGet),
        .regSet     (regSet),
        .clr_req    (clr_req),
        .writeData  (writeData),
        .LUTaddr    (LUTaddr),
        .opRegAddr  (opRegAddr),
        .opRegAddrB (opRegAddrB),
        .accData    (accData),
        .opRegData  (opRegData),
        .opRegDataB (opRegDataB),
        .busy       (busy),
        .clr_done   (clr_done),
        .wr_drop    (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        LUTSet = 0; regWrite = 0; regGet = 0; regSet = 0; clr_req = 0;
        writeData = 0; LUTaddr = 0; opRegAddr = 0; opRegAddrB = 0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] v);
        regWrite = 1; writeData = v; tick(); regWrite = 0;
        regSet = 1; opRegAddr = a; tick(); regSet = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        #12;
        reset_n = 1;
        tick();
        for (int a = 0; a < 16; a++) begin
            opRegAddr = 4'(a); opRegAddrB = 4'(15 - a);
            #1;
            checks++;
            if (opRegData !== 8'h00 || opRegDataB !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr %0d: A=%h B=%h, required 00/00", a, opRegData, opRegDataB);
            end
        end
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b clr_done=%b wr_drop=%b, required 0/0/0", busy, clr_done, wr_drop);
        end
    endtask

    task automatic test_write_set_get();
        regWrite = 1; writeData = 8'h5A;
        #1;
        checks++;
        if (accData !== 8'h00) begin
            errors++;
            $display("FAIL no_bypass: acc=%h, required 00", accData);
        end
        tick(); regWrite = 0;
        regSet = 1; opRegAddr = 3; tick(); regSet = 0;
        regWrite = 1; writeData = 8'h11; tick(); regWrite = 0;
        checks++;
        if (accData !== 8'h11) begin
            errors++;
            $display("FAIL write_acc: acc=%h, required 11", accData);
        end
        regGet = 1; opRegAddr = 3; tick(); regGet = 0;
        opRegAddrB = 3;
        #1;
        checks++;
        if (accData !== 8'h5A || opRegData !== 8'h5A || opRegDataB !== 8'h5A) begin
            errors++;
            $display("FAIL get_set: acc=%h reg3=%h B=%h, required 5a/5a/5a", accData, opRegData, opRegDataB);
        end
    endtask

    task automatic test_priority();
        LUTSet = 1; LUTaddr = 8'h20; regWrite = 1; writeData = 8'hFF;
        regGet = 1; regSet = 1; opRegAddr = 3;
        tick();
        idle_inputs();
        opRegAddr = 3;
        #1;
        checks++;
        if (accData !== 8'h20 || opRegData !== 8'h5A) begin
            errors++;
            $display("FAIL priority: acc=%h reg3=%h, required 20/5a", accData, opRegData);
        end
        regSet = 1; opRegAddr = 0; tick(); regSet = 0;
        checks++;
        if (accData !== 8'h20) begin
            errors++;
            $display("FAIL set_addr0: acc=%h, required 20", accData);
        end
        regGet = 1; opRegAddr = 0; tick(); regGet = 0;
        checks++;
        if (accData !== 8'h20) begin
            errors++;
            $display("FAIL get_addr0: acc=%h, required 20", accData);
        end
    endtask

    task automatic test_clear();
        int n;
        logic [7:0] orall;
        for (int a = 1; a < 16; a++) write_reg(4'(a), 8'(a));
        regWrite = 1; writeData = 8'h77; tick(); regWrite = 0;
        clr_req = 1; tick(); clr_req = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 1) begin
                opRegAddr = 15; opRegAddrB = 14;
                #1;
                checks++;
                if (opRegData !== 8'h00 || opRegDataB !== 8'h0E || accData !== 8'h77) begin
                    errors++;
                    $display("FAIL sweep_order: reg15=%h reg14=%h acc=%h, required 00/0e/77", opRegData, opRegDataB, accData);
                end
            end
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL busy_len: %0d cycles, required 16", n);
        end
        checks++;
        if (clr_done !== 1'b1) begin
            errors++;
            $display("FAIL clr_done_pulse: %b, required 1", clr_done);
        end
        tick();
        checks++;
        if (clr_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_done_single: clr_done=%b busy=%b, required 0/0", clr_done, busy);
        end
        orall = 8'h00;
        for (int a = 0; a < 16; a++) begin
            opRegAddr = 4'(a);
            #1;
            orall = orall | opRegData;
        end
        checks++;
        if (orall !== 8'h00) begin
            errors++;
            $display("FAIL all_cleared: OR of regs=%h, required 00", orall);
        end
    endtask

    task automatic test_clear_drop();
        int n;
        write_reg(5, 8'h55);
        regWrite = 1; writeData = 8'h33; tick(); regWrite = 0;
        clr_req = 1; tick(); clr_req = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            regWrite = (n == 3);
            writeData = (n == 3) ? 8'hAA : 8'h00;
            clr_req = (n == 5);
            tick();
            n++;
            regWrite = 0; clr_req = 0;
            if (n == 4) begin
                opRegAddr = 5;
                #1;
                checks++;
                if (wr_drop !== 1'b1 || accData !== 8'h33 || opRegData !== 8'h55) begin
                    errors++;
                    $display("FAIL drop_pulse: wr_drop=%b acc=%h reg5=%h, required 1/33/55", wr_drop, accData, opRegData);
                end
            end
            if (n == 5) begin
                checks++;
                if (wr_drop !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_single: wr_drop=%b, required 0", wr_drop);
                end
            end
        end
        checks++;
        if (n !== 16 || clr_done !== 1'b1) begin
            errors++;
            $display("FAIL no_restart: %0d cycles clr_done=%b, required 16/1", n, clr_done);
        end
        regWrite = 1; writeData = 8'h3C; tick(); regWrite = 0;
        checks++;
        if (accData !== 8'h3C || busy !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL done_write: acc=%h busy=%b wr_drop=%b, required 3c/0/0", accData, busy, wr_drop);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int seen;
        write_reg(7, 8'h77);
        clr_req = 1; regWrite = 1; writeData = 8'hEE; tick();
        clr_req = 0; regWrite = 0;
        checks++;
        if (busy !== 1'b1 || accData !== 8'h77 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL clr_outranks: busy=%b acc=%h wr_drop=%b, required 1/77/0", busy, accData, wr_drop);
        end
        for (int i = 0; i < 5; i++) tick();
        reset_n = 0;
        opRegAddr = 7;
        #1;
        checks++;
        if (opRegData !== 8'h00 || accData !== 8'h00 || busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: reg7=%h acc=%h busy=%b clr_done=%b, required 00/00/0/0", opRegData, accData, busy, clr_done);
        end
        tick();
        reset_n = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset: %0d busy/done cycles, required 0", seen);
        end
        regWrite = 1; writeData = 8'h42; tick(); regWrite = 0;
        checks++;
        if (accData !== 8'h42) begin
            errors++;
            $display("FAIL resume: acc=%h, required 42", accData);
        end
    endtask

    initial begin
        test_reset();
        test_write_set_get();
        test_priority();
        test_clear();
        test_clear_drop();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
